// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - MEM-stage data access as a handshake bus master with pipeline stall
`timescale 1ns/1ps
module data_mem_bridge #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [2:0]  FUNCT3_MEM,
    input  logic [31:0] ALU_OUT_MEM,
    input  logic [31:0] REG_DATA2_MEM_FINAL,
    output logic        mem_stall,
    output logic [31:0] DATA_MEMORY_MEM,
    output logic        mem_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    // Last REQ cycle index before the access is declared timed out
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        lane_q, lane_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       data_q, data_d;
    logic              fault_q, fault_d;

    logic              access, is_store, is_load, illegal, legal;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    // Decode the presented access: legality, byte enables and lane-replicated store data
    always_comb begin
        access    = MemRead_MEM | MemWrite_MEM;
        is_store  = MemWrite_MEM;
        is_load   = MemRead_MEM & ~MemWrite_MEM;
        illegal   = 1'b0;
        be_new    = 4'b1111;
        wdata_new = REG_DATA2_MEM_FINAL;
        if ((FUNCT3_MEM == 3'b011) || (FUNCT3_MEM[2:1] == 2'b11))
            illegal = 1'b1;
        if (is_store && FUNCT3_MEM[2])
            illegal = 1'b1;
        if ((FUNCT3_MEM[1:0] == 2'b01) && ALU_OUT_MEM[0])
            illegal = 1'b1;
        if ((FUNCT3_MEM[1:0] == 2'b10) && (ALU_OUT_MEM[1:0] != 2'b00))
            illegal = 1'b1;
        illegal = illegal & access;
        legal   = access & ~illegal;
        case (FUNCT3_MEM[1:0])
            2'b00: begin
                be_new    = 4'b0001 << ALU_OUT_MEM[1:0];
                wdata_new = {4{REG_DATA2_MEM_FINAL[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {ALU_OUT_MEM[1], 1'b0};
                wdata_new = {2{REG_DATA2_MEM_FINAL[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = REG_DATA2_MEM_FINAL;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    // Next-state logic: IDLE latches the request, REQ waits for the slave, DONE releases the pipeline
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        lane_d    = lane_q;
        f3_d      = f3_q;
        data_d    = data_q;
        fault_d   = 1'b0;
        mem_stall = 1'b0;
        mem_fault = fault_q;
        case (state_q)
            S_IDLE: begin
                if (legal) begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = is_store;
                    addr_d    = {ALU_OUT_MEM[31:2], 2'b00};
                    be_d      = be_new;
                    wdata_d   = wdata_new;
                    lane_d    = ALU_OUT_MEM[1:0];
                    f3_d      = FUNCT3_MEM;
                    cnt_d     = '0;
                    state_d   = S_REQ;
                end else if (illegal) begin
                    mem_fault = 1'b1;
                    if (is_load)
                        data_d = 32'd0;
                end
            end
            S_REQ: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (bus_ready) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (bus_err) begin
                        fault_d = 1'b1;
                        if (!we_q)
                            data_d = 32'd0;
                    end else if (!we_q) begin
                        data_d = load_ext;
                    end
                end else if (cnt_q == TO_LAST) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    fault_d = 1'b1;
                    if (!we_q)
                        data_d = 32'd0;
                end
            end
            default: begin
                // The held instruction is still presented here; ignore it so it is not reissued
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bus register update with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            lane_q  <= 2'd0;
            f3_q    <= 3'd0;
            data_q  <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            lane_q  <= lane_d;
            f3_q    <= f3_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    assign bus_req         = req_q;
    assign bus_we          = we_q;
    assign bus_addr        = addr_q;
    assign bus_be          = be_q;
    assign bus_wdata       = wdata_q;
    assign DATA_MEMORY_MEM = data_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - scoreboard bench for data_mem_bridge
`timescale 1ns/1ps
module tb_data_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead_MEM, MemWrite_MEM;
    logic [2:0]  FUNCT3_MEM;
    logic [31:0] ALU_OUT_MEM, REG_DATA2_MEM_FINAL;
    logic        mem_stall, mem_fault;
    logic [31:0] DATA_MEMORY_MEM;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready, bus_err;
    logic [31:0] bus_rdata;

    int vectors = 0;
    int errors  = 0;

    int          slv_waits = 0;
    logic [31:0] slv_rdata = 32'd0;
    logic        slv_err   = 1'b0;
    logic        slv_hang  = 1'b0;

    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;
    typedef struct { logic fault; logic [31:0] data; int stall; } rsp_exp_t;
    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    data_mem_bridge #(.TIMEOUT(4), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .FUNCT3_MEM(FUNCT3_MEM), .ALU_OUT_MEM(ALU_OUT_MEM),
        .REG_DATA2_MEM_FINAL(REG_DATA2_MEM_FINAL),
        .mem_stall(mem_stall), .DATA_MEMORY_MEM(DATA_MEMORY_MEM), .mem_fault(mem_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: answers after slv_waits wait cycles unless hung
    initial begin
        int wcnt;
        wcnt = 0;
        bus_ready = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            bus_rdata = slv_rdata;
            if (bus_req && !reset) begin
                if (!slv_hang && wcnt == slv_waits) begin
                    bus_ready = 1'b1; bus_err = slv_err;
                end else begin
                    bus_ready = 1'b0; bus_err = 1'b0;
                end
                wcnt++;
            end else begin
                bus_ready = 1'b0; bus_err = 1'b0; wcnt = 0;
            end
        end
    end

    // Monitor: pops bus expectations on each new request and response expectations on completion
    initial begin
        int cnt;
        logic prev, pend;
        logic [31:0] pdata;
        bus_exp_t b;
        rsp_exp_t r;
        cnt = 0; prev = 1'b0; pend = 1'b0; pdata = 32'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                cnt = 0; pend = 1'b0; prev = bus_req;
                continue;
            end
            if (pend) begin
                chk("data_after_illegal", DATA_MEMORY_MEM, pdata);
                pend = 1'b0;
            end
            if (bus_req && !prev) begin
                if (bus_q.size() == 0) begin
                    chk("spurious_bus_req", 32'(bus_req), 32'd0);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_we", 32'(bus_we), 32'(b.we));
                    chk("bus_addr", bus_addr, b.addr);
                    chk("bus_be", 32'(bus_be), 32'(b.be));
                    chk("bus_wdata", bus_wdata, b.wdata);
                end
            end
            prev = bus_req;
            if (mem_stall) begin
                cnt++;
            end else if (cnt > 0 || mem_fault) begin
                if (rsp_q.size() == 0) begin
                    chk("spurious_fault", 32'(mem_fault), 32'd0);
                    chk("spurious_stall", 32'(cnt), 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("stall_cycles", 32'(cnt), 32'(r.stall));
                    chk("mem_fault", 32'(mem_fault), 32'(r.fault));
                    if (cnt > 0) chk("load_data", DATA_MEMORY_MEM, r.data);
                    else begin pend = 1'b1; pdata = r.data; end
                end
                cnt = 0;
            end
        end
    end

    task automatic finish_access();
        int n;
        n = 0;
        @(negedge clk);
        while (mem_stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (mem_stall) begin
            vectors++; errors++;
            $display("FAIL stall_bound: stall still %0b after %0d cycles, required 0", mem_stall, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] rdata, input logic err, input logic hang,
                          input logic ebus, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic efault, input logic [31:0] edata, input int estall);
        bus_exp_t b;
        rsp_exp_t r;
        slv_waits = waits; slv_rdata = rdata; slv_err = err; slv_hang = hang;
        if (ebus) begin
            b.we = wr; b.addr = {a[31:2], 2'b00}; b.be = ebe; b.wdata = ewd;
            bus_q.push_back(b);
        end
        r.fault = efault; r.data = edata; r.stall = estall;
        rsp_q.push_back(r);
        MemRead_MEM = rd; MemWrite_MEM = wr; FUNCT3_MEM = f3;
        ALU_OUT_MEM = a; REG_DATA2_MEM_FINAL = wd;
        finish_access();
    endtask

    task automatic idle_inputs();
        MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; FUNCT3_MEM = 3'b011;
        ALU_OUT_MEM = 32'h3; REG_DATA2_MEM_FINAL = 32'hFFFF_FFFF;
    endtask

    initial begin
        bus_exp_t b;
        int n;
        reset = 1'b1;
        idle_inputs();
        #22;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_data", DATA_MEMORY_MEM, 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        // Non-memory instruction with junk funct3/address: no stall, no fault
        repeat (2) begin
            @(negedge clk);
            chk("nomem_stall", 32'(mem_stall), 32'd0);
            chk("nomem_fault", 32'(mem_fault), 32'd0);
        end
        @(posedge clk); #1;
        //     rd wr f3      addr          wdata          w  rdata          err hang bus be      ewdata         flt data           stall
        access(1, 0, 3'b010, 32'h100,      32'h0,         3, 32'hDEADBEEF, 0, 0,  1, 4'b1111, 32'h0,         0, 32'hDEADBEEF,  5);
        access(1, 0, 3'b000, 32'h103,      32'h0,         0, 32'h80FF1234, 0, 0,  1, 4'b1000, 32'h0,         0, 32'hFFFFFF80,  2);
        access(1, 0, 3'b100, 32'h103,      32'h0,         0, 32'h80FF1234, 0, 0,  1, 4'b1000, 32'h0,         0, 32'h00000080,  2);
        access(0, 1, 3'b001, 32'h206,      32'h0000ABCD,  1, 32'h0,        0, 0,  1, 4'b1100, 32'hABCDABCD,  0, 32'h00000080,  3);
        access(1, 0, 3'b010, 32'h102,      32'h0,         0, 32'h0,        0, 0,  0, 4'b0000, 32'h0,         1, 32'h00000000,  0);
        access(1, 0, 3'b001, 32'h102,      32'h0,         0, 32'h80010000, 0, 0,  1, 4'b1100, 32'h0,         0, 32'hFFFF8001,  2);
        access(1, 0, 3'b101, 32'h102,      32'h0,         2, 32'h80010000, 0, 0,  1, 4'b1100, 32'h0,         0, 32'h00008001,  4);
        access(0, 1, 3'b000, 32'h001,      32'h123456A5,  0, 32'h0,        0, 0,  1, 4'b0010, 32'hA5A5A5A5,  0, 32'h00008001,  2);
        access(1, 0, 3'b011, 32'h000,      32'h0,         0, 32'h0,        0, 0,  0, 4'b0000, 32'h0,         1, 32'h00000000,  0);
        access(1, 0, 3'b010, 32'h024,      32'h0,         0, 32'h11223344, 0, 0,  1, 4'b1111, 32'h0,         0, 32'h11223344,  2);
        access(0, 1, 3'b100, 32'h008,      32'h1,         0, 32'h0,        0, 0,  0, 4'b0000, 32'h0,         1, 32'h11223344,  0);
        access(1, 1, 3'b010, 32'h030,      32'hCAFEF00D,  0, 32'h0,        0, 0,  1, 4'b1111, 32'hCAFEF00D,  0, 32'h11223344,  2);
        access(1, 0, 3'b010, 32'h010,      32'h0,         1, 32'h55555555, 1, 0,  1, 4'b1111, 32'h0,         1, 32'h00000000,  3);
        access(1, 0, 3'b010, 32'h024,      32'h0,         0, 32'h11223344, 0, 0,  1, 4'b1111, 32'h0,         0, 32'h11223344,  2);
        access(1, 0, 3'b010, 32'h020,      32'h0,         0, 32'h0,        0, 1,  1, 4'b1111, 32'h0,         1, 32'h00000000,  5);
        // Load a nonzero value, then abandon a hung load with reset
        access(1, 0, 3'b010, 32'h024,      32'h0,         0, 32'h11223344, 0, 0,  1, 4'b1111, 32'h0,         0, 32'h11223344,  2);
        slv_hang = 1'b1;
        b.we = 1'b0; b.addr = 32'h40; b.be = 4'b1111; b.wdata = 32'h0;
        bus_q.push_back(b);
        MemRead_MEM = 1'b1; MemWrite_MEM = 1'b0; FUNCT3_MEM = 3'b010;
        ALU_OUT_MEM = 32'h40; REG_DATA2_MEM_FINAL = 32'h0;
        n = 0;
        @(negedge clk);
        while (!bus_req && n < 10) begin @(negedge clk); n++; end
        chk("req_before_reset", 32'(bus_req), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        idle_inputs();
        #1;
        chk("async_bus_req", 32'(bus_req), 32'd0);
        chk("async_bus_addr", bus_addr, 32'd0);
        chk("async_bus_we", 32'(bus_we), 32'd0);
        chk("async_bus_wdata", bus_wdata, 32'd0);
        chk("async_data", DATA_MEMORY_MEM, 32'd0);
        chk("async_stall", 32'(mem_stall), 32'd0);
        chk("async_fault", 32'(mem_fault), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        slv_hang = 1'b0;
        @(posedge clk); #1;
        // Back-to-back sw then lw
        access(0, 1, 3'b010, 32'h050,      32'h55667788,  0, 32'h0,        0, 0,  1, 4'b1111, 32'h55667788,  0, 32'h00000000,  2);
        access(1, 0, 3'b010, 32'h054,      32'h0,         1, 32'h99AABBCC, 0, 0,  1, 4'b1111, 32'h0,         0, 32'h99AABBCC,  3);
        idle_inputs();
        repeat (4) @(posedge clk);
        #1;
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
